// File: rtl/fibo_pkg.sv
// fibo_pkg: shared state encoding and default widths for the Fibonacci generator
package fibo_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/fibo_adder.sv
// fibo_adder: unsigned WIDTH-bit add exposing the carry out
module fibo_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  assign {carry, sum} = a + b;
endmodule

// File: rtl/fibo_gen_param.sv
// fibo_gen_param: seeded Fibonacci term source on a valid/ready stream with wrap/stop overflow handling
module fibo_gen_param
  import fibo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             wrap_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] fibo_term,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  state_t state;
  logic [WIDTH-1:0] a, b, sum;
  logic [CNT_W-1:0] idx, num_q;
  logic a_ovf, b_ovf, wrap_q, carry, last, stop;
  fibo_adder #(.WIDTH(WIDTH)) u_add (.a(a), .b(b), .sum(sum), .carry(carry));
  // b_ovf on the current term means the next term would be a wrapped value
  assign last = idx == num_q - 1'b1;
  assign stop = last || (!wrap_q && b_ovf);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      {a, b, idx, num_q, a_ovf, b_ovf, wrap_q} <= '0;
      {out_valid, fibo_term, term_idx, busy, done, overflow} <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a <= seed0;
          b <= seed1;
          idx <= '0;
          {a_ovf, b_ovf, overflow} <= '0;
          num_q <= num_terms;
          wrap_q <= wrap_en;
          if (num_terms == '0) begin
            state <= ST_DONE;
            done <= 1'b1;
          end else begin
            state <= ST_RUN;
            {busy, out_valid} <= 2'b11;
            fibo_term <= seed0;
            term_idx <= '0;
          end
        end
        ST_RUN: if (out_ready) begin
          a <= b;
          a_ovf <= b_ovf;
          b <= sum;
          b_ovf <= carry | a_ovf | b_ovf;
          idx <= idx + 1'b1;
          overflow <= overflow | (wrap_q ? a_ovf : b_ovf);
          if (stop) begin
            state <= ST_DONE;
            {busy, out_valid} <= 2'b00;
            done <= 1'b1;
          end else begin
            fibo_term <= b;
            term_idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fibo_gen_param.sv
// tb_fibo_gen_param: directed and randomized runs checked against an unbounded-integer Fibonacci model
module tb_fibo_gen_param;
  localparam int W = 8;
  localparam int CW = 8;
  logic clk = 0, reset = 1, start = 0, wrap_en = 0, out_ready = 0;
  logic [W-1:0] seed0 = 0, seed1 = 0;
  logic [CW-1:0] num_terms = 0;
  logic out_valid, busy, done, overflow;
  logic [W-1:0] fibo_term;
  logic [CW-1:0] term_idx;
  int checks = 0, errors = 0;

  fibo_gen_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .num_terms(num_terms), .wrap_en(wrap_en), .out_ready(out_ready),
    .out_valid(out_valid), .fibo_term(fibo_term), .term_idx(term_idx),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready always 1, mode 1: ready pattern 1,0,0,1, mode 2: random ready
  task automatic run(input logic [W-1:0] s0, input logic [W-1:0] s1, input int n,
                     input bit w, input int mode, input bit poke, output int done_cyc);
    longint t[$];
    longint q[$];
    int eidx = 0, cyc = 1;
    bit eovf = 0, fovf = 0, pv = 0, pr = 1, hs;
    logic [W-1:0] pt = 0, last_t = 0;
    logic [CW-1:0] pi = 0;
    // true (unbounded) term values decide both wrapping and stopping
    t.push_back(s0);
    t.push_back(s1);
    for (int i = 2; i <= n + 1; i++) t.push_back(t[i-1] + t[i-2]);
    for (int i = 0; i <= n; i++) begin
      if (!w && t[i] > 255) begin fovf = 1; break; end
      if (i == n) break;
      q.push_back(t[i]);
      if (t[i] > 255) fovf = 1;
    end
    done_cyc = -1;
    @(negedge clk);
    seed0 = s0; seed1 = s1; num_terms = CW'(n); wrap_en = w; start = 1;
    @(negedge clk);
    start = 0;
    chk("first_valid", out_valid, n != 0);
    while (cyc <= 400) begin
      if (out_valid && pv && !pr) begin
        chk("hold_term", fibo_term, pt);
        chk("hold_idx", term_idx, pi);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("extra_term", out_valid, 0);
        else begin
          chk("term", fibo_term, q[0] & 255);
          chk("idx", term_idx, eidx);
        end
      end
      if (done) begin done_cyc = cyc; break; end
      chk("ovf_run", overflow, eovf);
      chk("busy_run", busy, out_valid);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 1) : 1'($urandom_range(0, 1));
      hs = out_valid && out_ready;
      pv = out_valid; pr = out_ready; pt = fibo_term; pi = term_idx;
      if (hs && q.size() != 0) begin
        if (w && q[0] > 255) eovf = 1;
        last_t = W'(q[0] & 255);
        void'(q.pop_front());
        eidx++;
      end
      if (poke) begin
        start = cyc == 3;
        seed0 = 8'd77; seed1 = 8'd99; num_terms = 8'd2;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    if (done_cyc < 0) chk("timeout", 0, 1);
    else begin
      chk("left_terms", q.size(), 0);
      chk("ovf_final", overflow, fovf);
      chk("done_valid", out_valid, 0);
      chk("done_busy", busy, 0);
      if (n != 0) chk("done_keep_term", fibo_term, last_t);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int dc;
    int guard;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_term", fibo_term, 0);
    chk("rst_idx", term_idx, 0);
    chk("rst_flags", {busy, done, overflow}, 0);
    reset = 0;
    run(0, 1, 10, 1, 0, 0, dc);
    chk("done_latency", dc, 11);
    run(0, 1, 10, 1, 1, 0, dc);
    run(0, 1, 20, 0, 0, 0, dc);
    run(0, 1, 16, 1, 2, 0, dc);
    run(0, 1, 0, 1, 0, 0, dc);
    chk("zero_done_latency", dc, 1);
    run(3, 4, 12, 1, 0, 1, dc);
    // reset in the middle of a run, once idx 5 is on the bus
    @(negedge clk);
    seed0 = 0; seed1 = 1; num_terms = 10; wrap_en = 1; start = 1; out_ready = 1;
    @(negedge clk);
    start = 0;
    guard = 0;
    while (!(out_valid && term_idx == 5) && guard < 50) begin @(negedge clk); guard++; end
    chk("reach_idx5", guard < 50, 1);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_term", fibo_term, 0);
    chk("mid_rst_done", done, 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    for (int k = 0; k < 12; k++)
      run(W'($urandom), W'($urandom), $urandom_range(0, 30), 1'($urandom_range(0, 1)), 2, 0, dc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
